// File: rtl/split_result_collector_if.sv
// split_result_collector_if: upstream result stream and packed-word output handshake bundle.
// Carries out_parity only when SPLIT_COLLECT_PARITY_EN is defined.
interface split_result_collector_if #(
    parameter int RESULT_W = 4,
    parameter int DEPTH    = 4
);
    logic                      in_valid;
    logic                      in_ready;
    logic [RESULT_W-1:0]       in_result;
    logic                      in_last;
    logic                      out_valid;
    logic                      out_ready;
    logic [2*RESULT_W-1:0]     out_data;
    logic                      out_half;
    logic [$clog2(DEPTH):0]    count;
`ifdef SPLIT_COLLECT_PARITY_EN
    logic                      out_parity;
`endif

    modport master (
        output in_valid, in_result, in_last, out_ready,
        input  in_ready, out_valid, out_data, out_half, count
`ifdef SPLIT_COLLECT_PARITY_EN
        , input out_parity
`endif
    );

    modport slave (
        input  in_valid, in_result, in_last, out_ready,
        output in_ready, out_valid, out_data, out_half, count
`ifdef SPLIT_COLLECT_PARITY_EN
        , output out_parity
`endif
    );
endinterface

// File: rtl/split_result_collector.sv
// split_result_collector: packs result pairs into {second, first} words in a FWFT FIFO.
// Define SPLIT_COLLECT_PARITY_EN to store and report a per-word XOR parity bit.
module split_result_collector #(
    parameter int RESULT_W = 4,
    parameter int DEPTH    = 4
) (
    input logic                   clk,
    input logic                   rst_n,
    split_result_collector_if.slave bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int W  = 2 * RESULT_W;

    typedef enum logic {IDLE, HAVE_LOW} state_t;

    state_t              state;
    logic [RESULT_W-1:0] hold;
    logic [AW-1:0]       wr_ptr, rd_ptr;
    logic [AW:0]         count_q;
    logic [W-1:0]        data_mem [DEPTH];
    logic                half_mem [DEPTH];
    logic                full, empty, pop, acc, push;
    logic [W-1:0]        push_word;

    assign full      = count_q == (AW+1)'(DEPTH);
    assign empty     = count_q == '0;
    assign pop       = !empty && bus.out_ready;
    assign bus.in_ready = (state == IDLE && !bus.in_last) || !full || pop;
    assign acc       = bus.in_valid && bus.in_ready;
    assign push      = acc && (state == HAVE_LOW || bus.in_last);
    assign push_word = state == HAVE_LOW ? {bus.in_result, hold} : {{RESULT_W{1'b0}}, bus.in_result};

    assign bus.out_valid = !empty;
    assign bus.out_data  = empty ? '0 : data_mem[rd_ptr];
    assign bus.out_half  = !empty && half_mem[rd_ptr];
    assign bus.count     = count_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            hold    <= '0;
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
        end else begin
            if (acc) begin
                state <= (state == IDLE && !bus.in_last) ? HAVE_LOW : IDLE;
                hold  <= (state == IDLE && !bus.in_last) ? bus.in_result : hold;
            end
            wr_ptr  <= wr_ptr + AW'(push);
            rd_ptr  <= rd_ptr + AW'(pop);
            count_q <= count_q + (AW+1)'(push) - (AW+1)'(pop);
        end
    end

    // Storage needs no reset: an empty count masks stale entries.
    always_ff @(posedge clk) begin
        if (push) begin
            data_mem[wr_ptr] <= push_word;
            half_mem[wr_ptr] <= state == IDLE;
        end
    end

`ifdef SPLIT_COLLECT_PARITY_EN
    logic par_mem [DEPTH];

    always_ff @(posedge clk) begin
        if (push) par_mem[wr_ptr] <= ^push_word;
    end

    assign bus.out_parity = !empty && par_mem[rd_ptr];
`endif
endmodule

// File: tb/tb_split_result_collector.sv
// tb_split_result_collector: directed stimulus with a queue-based packing model checked every cycle.
// Builds with or without SPLIT_COLLECT_PARITY_EN.
module tb_split_result_collector;
    localparam int RW = 4;
    localparam int DEPTH = 4;

    logic clk = 0;
    logic rst_n = 0;
    int   errs = 0;
    int   checks = 0;

    split_result_collector_if #(.RESULT_W(RW), .DEPTH(DEPTH)) bus ();

    split_result_collector #(.RESULT_W(RW), .DEPTH(DEPTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Model: queue of {half, word}, plus one optionally held low result.
    logic [2*RW:0] q[$];
    logic          mhave;
    logic [RW-1:0] mhold;

    function automatic bit model_ready();
        return (!mhave && !bus.in_last) || q.size() < DEPTH || (q.size() > 0 && bus.out_ready);
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q.delete();
            mhave <= 1'b0;
            mhold <= '0;
        end else begin
            automatic bit rdy = model_ready();
            if (q.size() > 0 && bus.out_ready) void'(q.pop_front());
            if (bus.in_valid && rdy) begin
                if (mhave) q.push_back({1'b0, bus.in_result, mhold});
                else if (bus.in_last) q.push_back({1'b1, {RW{1'b0}}, bus.in_result});
                mhave <= !mhave && !bus.in_last;
                if (!mhave && !bus.in_last) mhold <= bus.in_result;
            end
        end
    end

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic compare();
        logic [2*RW:0] head;
        head = q.size() > 0 ? q[0] : '0;
        chk("m_out_valid", 16'(bus.out_valid), 16'(q.size() > 0));
        chk("m_out_data", 16'(bus.out_data), 16'(head[2*RW-1:0]));
        chk("m_out_half", 16'(bus.out_half), 16'(head[2*RW]));
        chk("m_count", 16'(bus.count), 16'(q.size()));
        chk("m_in_ready", 16'(bus.in_ready), 16'(model_ready()));
`ifdef SPLIT_COLLECT_PARITY_EN
        chk("m_out_parity", 16'(bus.out_parity), 16'(^head[2*RW-1:0]));
`endif
    endtask

    task automatic cyc(output bit rdy);
        @(negedge clk);
        compare();
        rdy = bus.in_ready;
        @(posedge clk);
        #1;
    endtask

    task automatic tick();
        bit r;
        cyc(r);
    endtask

    task automatic send(input logic [RW-1:0] r, input bit last);
        bit rdy;
        bus.in_valid = 1;
        bus.in_result = r;
        bus.in_last = last;
        rdy = 0;
        for (int n = 0; n < 50 && !rdy; n++) cyc(rdy);
        if (!rdy) chk("send_timeout", 16'(0), 16'(1));
        bus.in_valid = 0;
        bus.in_last = 0;
    endtask

    initial begin
        bus.in_valid = 0;
        bus.in_result = '0;
        bus.in_last = 0;
        bus.out_ready = 0;
        #12;
        chk("rst_out_valid", 16'(bus.out_valid), 16'(0));
        chk("rst_out_data", 16'(bus.out_data), 16'(0));
        chk("rst_count", 16'(bus.count), 16'(0));
        chk("rst_in_ready", 16'(bus.in_ready), 16'(1));
        @(posedge clk);
        #1 rst_n = 1;
        tick();

        // Basic pair
        bus.out_ready = 1;
        send(4'b1001, 0);
        send(4'b0110, 0);
        chk("pair_data", 16'(bus.out_data), 16'h69);
        chk("pair_half", 16'(bus.out_half), 16'(0));
        tick();
        chk("pair_count", 16'(bus.count), 16'(0));

        // Single flush
        send(4'b1111, 1);
        chk("flush_data", 16'(bus.out_data), 16'h0F);
        chk("flush_half", 16'(bus.out_half), 16'(1));
`ifdef SPLIT_COLLECT_PARITY_EN
        chk("flush_parity", 16'(bus.out_parity), 16'(0));
`endif
        tick();

        // Fill with sink stalled
        bus.out_ready = 0;
        for (int k = 0; k < 8; k++) send(RW'(k), 0);
        chk("fill_count", 16'(bus.count), 16'(4));
        chk("fill_ready_idle", 16'(bus.in_ready), 16'(1));
        send(4'd8, 0);
        bus.in_valid = 1;
        bus.in_result = 4'd9;
        #1;
        chk("full_ready_low", 16'(bus.in_ready), 16'(0));
        chk("full_head", 16'(bus.out_data), 16'h10);
        bus.out_ready = 1;
        #1;
        chk("full_ready_pop", 16'(bus.in_ready), 16'(1));
        tick();
        bus.in_valid = 0;
        chk("pushpop_count", 16'(bus.count), 16'(4));
        chk("wrap_w1", 16'(bus.out_data), 16'h32);
        tick();
        chk("wrap_w2", 16'(bus.out_data), 16'h54);
        tick();
        chk("wrap_w3", 16'(bus.out_data), 16'h76);
        tick();
        chk("wrap_w4", 16'(bus.out_data), 16'h98);
        tick();
        chk("drain_count", 16'(bus.count), 16'(0));

        // Reset in HAVE_LOW with two words queued
        bus.out_ready = 0;
        for (int k = 1; k <= 5; k++) send(RW'(k), 0);
        chk("pre_rst_count", 16'(bus.count), 16'(2));
        #2 rst_n = 0;
        #1;
        chk("mid_rst_valid", 16'(bus.out_valid), 16'(0));
        chk("mid_rst_count", 16'(bus.count), 16'(0));
        tick();
        rst_n = 1;
        bus.out_ready = 1;
        send(4'b0011, 1);
        chk("post_rst_data", 16'(bus.out_data), 16'h03);
        chk("post_rst_half", 16'(bus.out_half), 16'(1));
        tick();

        // Sweep 0..14 with odd trailing flush
        for (int k = 0; k < 15; k++) send(RW'(k), k == 14);
        chk("sweep_tail_data", 16'(bus.out_data), 16'h0E);
        chk("sweep_tail_half", 16'(bus.out_half), 16'(1));
        for (int k = 0; k < 3; k++) tick();
        chk("sweep_count", 16'(bus.count), 16'(0));

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule
